stage_if: RTL

- Instruction-fetch stage. Owns the PC and fetches 32-bit instructions over the byte-wide memory port, four bytes per instruction.
- Presents pc/inst to the IF/ID latch feeding stage_id.
- Consumes stage_id's br/br_addr redirect and the pipeline stall bus.
- Raises stall_if while no complete instruction is available.

---
 rtl/stage_if_pkg.sv | 21 ++
 rtl/stage_if_if.sv | 24 ++
 rtl/stage_if.sv | 139 +++++++++++++
 3 files changed

// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stage_if_pkg;

    localparam int STALL_W    = 6;
    localparam int STALL_IFID = 1;
    localparam int STALL_ID   = 2;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [STALL_W-1:0] stall_bus_t;
    typedef logic [31:0]        addr_t;
    typedef logic [31:0]        inst_t;
    typedef logic [7:0]         byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } if_state_e;

endpackage

// File: rtl/stage_if_if.sv
// Byte-wide memory read port between the fetch stage and the memory arbiter.
interface stage_if_if;
    import stage_if_pkg::*;

    logic  mem_req;
    addr_t mem_addr;
    logic  mem_grant;
    byte_t mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_grant,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_grant,
        output mem_rdata
    );

endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC and assembles each 32-bit instruction
// from four byte reads, little-endian, over a granted memory port.
module stage_if
    import stage_if_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0
)
(
    input  logic       clk,
    input  logic       reset,
    input  stall_bus_t stall,
    output logic       stall_if,
    input  logic       br,
    input  addr_t      br_addr,
    output addr_t      pc,
    output inst_t      inst,
    output logic       inst_valid,
    stage_if_if.master mem
);

    if_state_e state;
    if_state_e state_next;

    logic [2:0] icnt;
    logic [2:0] rcnt;
    logic       pending;
    byte_t      byte_buf [3];

    logic req;
    logic br_taken;
    logic issue;
    logic last_byte;
    logic unused_stall;

    assign br_taken     = br & ~stall[STALL_ID];
    assign issue        = req & mem.mem_grant;
    assign last_byte    = pending && (rcnt == 3'd3);
    assign unused_stall = ^{stall[STALL_W-1:3], stall[0]};

    assign mem.mem_req  = req;
    assign mem.mem_addr = req ? (pc + {29'd0, icnt}) : ZERO_WORD;

    // State register; reset parks the stage in IDLE for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus request/stall outputs; a taken redirect always restarts a fetch.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        stall_if   = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                stall_if = 1'b1;
                req      = (icnt < 3'd4);
                if (last_byte) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!stall[STALL_IFID]) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (br_taken) begin
            state_next = FETCH;
        end
    end

    // PC, counters and byte assembly; the fourth byte goes straight into inst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            inst       <= ZERO_WORD;
            inst_valid <= 1'b0;
            icnt       <= 3'd0;
            rcnt       <= 3'd0;
            pending    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                byte_buf[i] <= '0;
            end
        end else if (br_taken) begin
            pc         <= br_addr;
            inst       <= ZERO_WORD;
            inst_valid <= 1'b0;
            icnt       <= 3'd0;
            rcnt       <= 3'd0;
            pending    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    icnt    <= 3'd0;
                    rcnt    <= 3'd0;
                    pending <= 1'b0;
                end
                FETCH: begin
                    pending <= issue;
                    if (issue) begin
                        icnt <= icnt + 3'd1;
                    end
                    if (pending) begin
                        rcnt <= rcnt + 3'd1;
                        if (last_byte) begin
                            inst       <= {mem.mem_rdata, byte_buf[2], byte_buf[1], byte_buf[0]};
                            inst_valid <= 1'b1;
                        end else begin
                            byte_buf[rcnt[1:0]] <= mem.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    pending <= 1'b0;
                    if (!stall[STALL_IFID]) begin
                        pc         <= pc + 32'd4;
                        inst_valid <= 1'b0;
                        icnt       <= 3'd0;
                        rcnt       <= 3'd0;
                    end
                end
                default: begin
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
